// File: rtl/neuron_cfg_tx_pkg.sv
// Shared neuron package.
// Holds the neuron mode constants, the configuration frame-class encodings,
// the per-class frame lengths and the state encoding of the configuration
// serializer FSM.
package neuron_cfg_tx_pkg;

  // Neuron mode payloads carried in the low six bits of a MODE frame opcode.
  localparam logic [5:0] MODE_IDLE  = 6'h00;
  localparam logic [5:0] MODE_LIF   = 6'h01;
  localparam logic [5:0] MODE_IZH   = 6'h02;
  localparam logic [5:0] MODE_LEARN = 6'h04;

  // Frame class lives in opcode bits [7:6].
  typedef enum logic [1:0] {
    CLS_MODE   = 2'b00,
    CLS_WEIGHT = 2'b01,
    CLS_VALUE  = 2'b10,
    CLS_COMMIT = 2'b11
  } frame_cls_t;

  // Frame lengths in bytes; they fit the 3-bit byte counter.
  localparam logic [2:0] LEN_MODE   = 3'd1;
  localparam logic [2:0] LEN_WEIGHT = 3'd7;
  localparam logic [2:0] LEN_VALUE  = 3'd5;
  localparam logic [2:0] LEN_COMMIT = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10
  } tx_state_t;

  function automatic logic [2:0] frame_len(input frame_cls_t cls);
    logic [2:0] len;
    case (cls)
      CLS_MODE:   len = LEN_MODE;
      CLS_WEIGHT: len = LEN_WEIGHT;
      CLS_VALUE:  len = LEN_VALUE;
      default:    len = LEN_COMMIT;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/neuron_cfg_tx.sv
// neuron_cfg_tx: serializes one host configuration command into a byte
// frame for the neuron byte port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_op                   opcode, [7:6] frame class, [5:0] payload
//   cmd_addr, cmd_value      synapse/source address and 32-bit value
//   data / load_data         output byte and its strobe (data=0 when idle)
//   busy                     frame in progress (== !cmd_ready)
//   frame_done               pulse with the last byte of each frame
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, so a request
// raised while a frame is running is simply not seen (no queueing). The
// fields are captured at the transfer edge; later input changes do not
// affect the frame. Byte 0 is driven in the cycle after the transfer.
//
// Parameter GAP (0..15): idle cycles between consecutive bytes of a frame.
module neuron_cfg_tx
  import neuron_cfg_tx_pkg::*;
#(
  parameter int GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [9:0]  cmd_addr,
  input  logic [31:0] cmd_value,
  output logic [7:0]  data,
  output logic        load_data,
  output logic        busy,
  output logic        frame_done
);

  // Terminal value of the gap counter; unused when GAP is zero.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  tx_state_t   state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [3:0]  gap_cnt, gap_cnt_nx;
  logic [7:0]  op_q;
  logic [9:0]  addr_q;
  logic [31:0] value_q;

  logic        accept;
  logic        last_byte;
  frame_cls_t  cls;
  logic [7:0]  byte_sel;

  assign accept    = cmd_valid && cmd_ready;
  assign cls       = frame_cls_t'(op_q[7:6]);
  assign last_byte = (cnt == frame_len(cls) - 3'd1);

  // Outputs are decoded from registered state only, so an asynchronous
  // reset silences the byte port in the same cycle.
  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign load_data  = (state == ST_SEND);
  assign frame_done = (state == ST_SEND) && last_byte;
  assign data       = load_data ? byte_sel : 8'h00;

  // Byte-select mux: class picks the frame layout, counter picks the byte.
  always_comb begin
    byte_sel = op_q;
    case (cls)
      CLS_WEIGHT: begin
        case (cnt)
          3'd1:    byte_sel = {6'b0, addr_q[9:8]};
          3'd2:    byte_sel = addr_q[7:0];
          3'd3:    byte_sel = value_q[31:24];
          3'd4:    byte_sel = value_q[23:16];
          3'd5:    byte_sel = value_q[15:8];
          3'd6:    byte_sel = value_q[7:0];
          default: byte_sel = op_q;
        endcase
      end
      CLS_VALUE: begin
        case (cnt)
          3'd1:    byte_sel = value_q[31:24];
          3'd2:    byte_sel = value_q[23:16];
          3'd3:    byte_sel = value_q[15:8];
          3'd4:    byte_sel = value_q[7:0];
          default: byte_sel = op_q;
        endcase
      end
      default: byte_sel = op_q;
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    gap_cnt_nx = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SEND;
          cnt_nx   = 3'd0;
        end
      end
      ST_SEND: begin
        if (last_byte) begin
          state_nx = ST_IDLE;
          cnt_nx   = 3'd0;
        end else begin
          cnt_nx = cnt + 3'd1;
          if (GAP > 0) begin
            state_nx   = ST_GAP;
            gap_cnt_nx = 4'd0;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = ST_SEND;
        end else begin
          gap_cnt_nx = gap_cnt + 4'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 8'h00;
      addr_q  <= 10'h000;
      value_q <= 32'h0;
    end else if (accept) begin
      op_q    <= cmd_op;
      addr_q  <= cmd_addr;
      value_q <= cmd_value;
    end
  end

endmodule

// File: tb/tb_neuron_cfg_tx.sv
// Testbench for neuron_cfg_tx. Two instances run side by side: index 0 with
// GAP=0 and index 1 with GAP=2. Expected frames come from a vector table and
// from a frame-building model; a negedge monitor checks every output cycle.
module tb_neuron_cfg_tx;

  logic        clk;
  logic        rst;
  logic        cmd_valid  [2];
  logic        cmd_ready  [2];
  logic [7:0]  cmd_op     [2];
  logic [9:0]  cmd_addr   [2];
  logic [31:0] cmd_value  [2];
  logic [7:0]  data       [2];
  logic        load_data  [2];
  logic        busy       [2];
  logic        frame_done [2];

  neuron_cfg_tx #(.GAP(0)) dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_addr(cmd_addr[0]), .cmd_value(cmd_value[0]),
    .data(data[0]), .load_data(load_data[0]), .busy(busy[0]),
    .frame_done(frame_done[0])
  );

  neuron_cfg_tx #(.GAP(2)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_addr(cmd_addr[1]), .cmd_value(cmd_value[1]),
    .data(data[1]), .load_data(load_data[1]), .busy(busy[1]),
    .frame_done(frame_done[1])
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: {last_flag, byte} per expected output byte.
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];

  function automatic int q_size(input int s);
    return (s == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [8:0] q_pop(input int s);
    if (s == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic q_push(input int s, input logic [8:0] e);
    if (s == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  // Reference frame builder: bytes left-justified in b, byte 0 in [55:48].
  task automatic model(input logic [7:0] op, input logic [9:0] addr,
                       input logic [31:0] val, output logic [55:0] b,
                       output int len);
    case (op[7:6])
      2'b01: begin len = 7; b = {op, 6'b0, addr[9:8], addr[7:0], val}; end
      2'b10: begin len = 5; b = {op, val, 16'h0}; end
      default: begin len = 1; b = {op, 48'h0}; end
    endcase
  endtask

  // Per-instance monitor state.
  bit acc_pending [2];
  bit done_prev   [2];
  bit in_frame    [2];
  int idle_cnt    [2];
  int busy_run    [2];
  int last_busy   [2];
  int last_done   [2];
  int prev_done   [2];

  task automatic mon(input int s);
    logic [8:0] e;
    int gapv;
    gapv = (s == 0) ? 0 : 2;
    check("busy_eq_not_ready", busy[s], !cmd_ready[s]);
    if (!load_data[s]) begin
      check("data_zero_when_idle", data[s], 8'h00);
      check("done_only_with_load", frame_done[s], 1'b0);
    end
    if (acc_pending[s]) begin
      check("byte0_latency", load_data[s], 1'b1);
      acc_pending[s] = 1'b0;
    end
    if (done_prev[s]) begin
      check("ready_after_last", cmd_ready[s], 1'b1);
      done_prev[s] = 1'b0;
    end
    if (busy[s]) busy_run[s]++;
    else busy_run[s] = 0;
    if (load_data[s]) begin
      if (q_size(s) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_byte inst%0d: got %0h expected no byte (cycle %0d)", s, data[s], cyc);
      end else begin
        e = q_pop(s);
        check("byte", data[s], e[7:0]);
        check("frame_done", frame_done[s], e[8]);
        if (in_frame[s]) check("gap_len", idle_cnt[s], gapv);
        in_frame[s] = !e[8];
      end
      idle_cnt[s] = 0;
      if (frame_done[s]) begin
        done_prev[s] = 1'b1;
        last_busy[s] = busy_run[s];
        prev_done[s] = last_done[s];
        last_done[s] = cyc;
      end
    end else if (in_frame[s]) begin
      idle_cnt[s]++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        acc_pending[s] = 0; done_prev[s] = 0; in_frame[s] = 0;
        idle_cnt[s] = 0; busy_run[s] = 0;
      end
    end else begin
      mon(0);
      mon(1);
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returning on a negedge. Waits (bounded) for cmd_ready, pushes
  // the expected bytes at the transfer edge.
  task automatic send_cmd(input int s, input logic [7:0] op, input logic [9:0] addr,
                          input logic [31:0] val, input logic [55:0] b,
                          input int len, input bit hold);
    int t;
    cmd_valid[s] = 1'b1;
    cmd_op[s]    = op;
    cmd_addr[s]  = addr;
    cmd_value[s] = val;
    t = 0;
    while (!cmd_ready[s]) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_timeout inst%0d: got ready=0 expected ready=1", s);
        cmd_valid[s] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    for (int i = 0; i < len; i++) q_push(s, {(i == len - 1), b[55 - 8*i -: 8]});
    acc_pending[s] = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int t;
    t = 0;
    while (!(cmd_ready[s] && q_size(s) == 0)) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL idle_timeout inst%0d: got %0d pending bytes expected 0", s, q_size(s));
        return;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          inst;
    logic [7:0]  op;
    logic [9:0]  addr;
    logic [31:0] value;
    int          len;
    logic [55:0] bytes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [55:0] mb;
    int          ml;
    logic [7:0]  rop;
    logic [9:0]  raddr;
    logic [31:0] rval;
    int          rs;

    vecs[0] = '{0, 8'h41, 10'h2A5, 32'hDEADBEEF, 7, 56'h41_02_A5_DE_AD_BE_EF};
    vecs[1] = '{1, 8'h82, 10'h000, 32'h00001234, 5, 56'h82_00_00_12_34_00_00};
    vecs[2] = '{0, 8'h05, 10'h3FF, 32'hFFFFFFFF, 1, 56'h05_00_00_00_00_00_00};
    vecs[3] = '{1, 8'hC0, 10'h155, 32'h12345678, 1, 56'hC0_00_00_00_00_00_00};
    vecs[4] = '{1, 8'h7F, 10'h155, 32'h01020304, 7, 56'h7F_01_55_01_02_03_04};
    vecs[5] = '{0, 8'hBF, 10'h0AA, 32'hA5A50F0F, 5, 56'hBF_A5_A5_0F_0F_00_00};

    for (int s = 0; s < 2; s++) begin
      cmd_valid[s] = 0; cmd_op[s] = 0; cmd_addr[s] = 0; cmd_value[s] = 0;
      last_done[s] = 0; prev_done[s] = 0; last_busy[s] = 0;
    end

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", cmd_ready[s], 1'b1);
      check("rst_load", load_data[s], 1'b0);
      check("rst_data", data[s], 8'h00);
      check("rst_busy", busy[s], 1'b0);
      check("rst_done", frame_done[s], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      send_cmd(vecs[v].inst, vecs[v].op, vecs[v].addr, vecs[v].value,
               vecs[v].bytes, vecs[v].len, 1'b0);
      wait_idle(vecs[v].inst);
      if (vecs[v].inst == 1 && vecs[v].op == 8'h82)
        check("value_gap2_busy_cycles", last_busy[1], 13);
    end

    // MODE then COMMIT with cmd_valid held: one idle cycle between them.
    send_cmd(0, 8'h05, 10'h0, 32'h0, 56'h05_00_00_00_00_00_00, 1, 1'b1);
    send_cmd(0, 8'hC0, 10'h0, 32'h0, 56'hC0_00_00_00_00_00_00, 1, 1'b0);
    wait_idle(0);
    check("b2b_done_spacing", last_done[0] - prev_done[0], 2);

    // Inputs disturbed mid-frame: frame unchanged, no extra frame.
    send_cmd(0, 8'h41, 10'h2A5, 32'hDEADBEEF, 56'h41_02_A5_DE_AD_BE_EF, 7, 1'b0);
    @(negedge clk);
    cmd_value[0] = 32'h0;
    cmd_op[0]    = 8'h00;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    wait_idle(0);
    repeat (3) @(negedge clk);
    check("no_extra_frame", q_size(0), 0);

    // Asynchronous reset after byte 3 of a WEIGHT frame.
    send_cmd(0, 8'h41, 10'h2A5, 32'hDEADBEEF, 56'h41_02_A5_DE_AD_BE_EF, 7, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_load", load_data[0], 1'b0);
    check("abort_data", data[0], 8'h00);
    check("abort_ready", cmd_ready[0], 1'b1);
    check("abort_done", frame_done[0], 1'b0);
    check("abort_busy", busy[0], 1'b0);
    exp_q0.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_cmd(0, 8'h82, 10'h0, 32'h00001234, 56'h82_00_00_12_34_00_00, 5, 1'b0);
    wait_idle(0);

    // Randomized commands against the frame model.
    for (int k = 0; k < 40; k++) begin
      rs    = $urandom_range(0, 1);
      rop   = 8'($urandom);
      raddr = 10'($urandom);
      rval  = $urandom;
      model(rop, raddr, rval, mb, ml);
      send_cmd(rs, rop, raddr, rval, mb, ml, 1'b0);
      if ($urandom_range(0, 3) == 0) wait_idle(rs);
    end
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    check("final_q0_empty", q_size(0), 0);
    check("final_q1_empty", q_size(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
